// File: rtl/pw_gen_multi.sv
// pw_gen_multi: NCH independent square-wave channels plus a one-cycle frame pulse.
// Define PW_GEN_READBACK_EN to add the registered half-period readback port cfg_rdata.
module pw_gen_multi #(
  parameter int NCH = 4,
  parameter int CW = 24,
  parameter logic [CW-1:0] DEF_HALF = CW'(24'h498bb2),
  parameter logic [24:0] FRAME_LEN = 25'h931765,
  localparam int CHW = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           locked,
  input  logic           en,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_half,
  input  logic [CW-1:0]  cfg_phase,
  output logic [NCH-1:0] sig_out,
  output logic           com
`ifdef PW_GEN_READBACK_EN
  ,
  output logic [CW-1:0]  cfg_rdata
);
`else
);
`endif
  logic run;
  logic last;
  logic [24:0] f;
  logic [CW-1:0] load;
  logic [NCH-1:0] wr;
  assign run = en & locked;
  assign load = cfg_phase > cfg_half ? '0 : cfg_phase;
  assign last = f == FRAME_LEN - 25'd1;
`ifdef PW_GEN_READBACK_EN
  logic [CW-1:0] h_all [NCH];
  logic [CW-1:0] rd;
  always_comb begin
    rd = '0;
    for (int i = 0; i < NCH; i++) rd = cfg_ch == CHW'(i) ? h_all[i] : rd;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) cfg_rdata <= '0;
    else cfg_rdata <= rd;
`endif
  for (genvar g = 0; g < NCH; g++) begin : ch
    logic [CW-1:0] h, c;
    logic s;
    assign wr[g] = cfg_we && cfg_ch == CHW'(g);
    assign sig_out[g] = s;
`ifdef PW_GEN_READBACK_EN
    assign h_all[g] = h;
`endif
    // a write replaces the counter without toggling, even on terminal count
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        h <= DEF_HALF;
        c <= '0;
        s <= 1'b1;
      end else begin
        if (wr[g]) h <= cfg_half;
        if (!run || (!wr[g] && h == '0)) begin
          c <= '0;
          s <= 1'b1;
        end else if (wr[g]) c <= load;
        else if (c == h) begin
          c <= '0;
          s <= ~s;
        end else c <= c + 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      f <= '0;
      com <= 1'b0;
    end else if (!run) begin
      f <= '0;
      com <= 1'b0;
    end else begin
      f <= last ? '0 : f + 25'd1;
      com <= last;
    end
endmodule
